// File: rtl/led_pattern_engine.sv
// led_pattern_engine
//
// Mode-selectable LED driver for the reaction-timer board. A single phase
// counter paces the BLINK and CHASE patterns. SINGLE lights the LED picked
// by led_sel. OFF blanks the bank.
//
// Parameters
//   NUM_LEDS    : number of LED outputs (>= 2)
//   HALF_PERIOD : clk cycles per pattern phase (>= 1)
//
// Ports
//   clk        in   1         system clock (single domain)
//   reset      in   1         synchronous, active-high reset
//   mode       in   2         00 OFF, 01 BLINK, 10 CHASE, 11 SINGLE
//   led_sel    in   SEL_W     LED index used in SINGLE mode
//   leds       out  NUM_LEDS  registered LED drive, 1 = on
//   phase_tick out  1         one-cycle pulse per BLINK/CHASE advance
//
// All outputs come straight from flops. The mode register doubles as the
// FSM state: a difference between the incoming mode and the stored mode
// marks an entry edge.

module led_pattern_engine #(
  parameter int NUM_LEDS    = 4,
  parameter int HALF_PERIOD = 50000000,
  localparam int CNT_W      = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1,
  localparam int SEL_W      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          mode,
  input  logic [SEL_W-1:0]    led_sel,
  output logic [NUM_LEDS-1:0] leds,
  output logic                phase_tick
);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_BLINK  = 2'b01,
    MODE_CHASE  = 2'b10,
    MODE_SINGLE = 2'b11
  } mode_e;

  // Last count value of a phase; the advance happens when cnt reaches it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HALF_PERIOD - 1);

  localparam logic [NUM_LEDS-1:0] LEDS_ZERO  = {NUM_LEDS{1'b0}};
  localparam logic [NUM_LEDS-1:0] LEDS_ONES  = {NUM_LEDS{1'b1}};
  localparam logic [NUM_LEDS-1:0] LEDS_FIRST = {{(NUM_LEDS-1){1'b0}}, 1'b1};

  // One-hot decode of an LED index. An index at or beyond NUM_LEDS yields
  // an all-off vector, which covers the non-power-of-two bank sizes.
  function automatic logic [NUM_LEDS-1:0] decode_sel(input logic [SEL_W-1:0] sel);
    logic [NUM_LEDS-1:0] result;
    result = LEDS_ZERO;
    for (int i = 0; i < NUM_LEDS; i++) begin
      if (int'(sel) == i) begin
        result[i] = 1'b1;
      end else begin
        result[i] = 1'b0;
      end
    end
    return result;
  endfunction

  // Rotate left by one; the top LED wraps around to LED 0.
  function automatic logic [NUM_LEDS-1:0] rotate_left(input logic [NUM_LEDS-1:0] v);
    return {v[NUM_LEDS-2:0], v[NUM_LEDS-1]};
  endfunction

  // LED pattern loaded on the edge a mode is entered.
  function automatic logic [NUM_LEDS-1:0] entry_pattern(input mode_e m,
                                                        input logic [SEL_W-1:0] sel);
    logic [NUM_LEDS-1:0] result;
    case (m)
      MODE_OFF:    result = LEDS_ZERO;
      MODE_BLINK:  result = LEDS_ONES;
      MODE_CHASE:  result = LEDS_FIRST;
      MODE_SINGLE: result = decode_sel(sel);
      default:     result = LEDS_ZERO;
    endcase
    return result;
  endfunction

  mode_e               mode_in_s;
  mode_e               mode_r;
  mode_e               mode_nxt_s;
  logic [CNT_W-1:0]    cnt_r;
  logic [CNT_W-1:0]    cnt_nxt_s;
  logic [NUM_LEDS-1:0] leds_r;
  logic [NUM_LEDS-1:0] leds_nxt_s;
  logic                tick_r;
  logic                tick_nxt_s;
  logic                entry_s;
  logic                term_s;

  assign mode_in_s = mode_e'(mode);
  assign entry_s   = (mode_in_s != mode_r);
  assign term_s    = (cnt_r == CNT_LAST);

  // Next-state logic: reset first, then mode entry, then steady behaviour.
  // Entry outranks a coincident terminal count, so a switch never ticks.
  always_comb begin
    mode_nxt_s = mode_r;
    cnt_nxt_s  = {CNT_W{1'b0}};
    leds_nxt_s = leds_r;
    tick_nxt_s = 1'b0;

    if (reset) begin
      mode_nxt_s = MODE_OFF;
      cnt_nxt_s  = {CNT_W{1'b0}};
      leds_nxt_s = LEDS_ZERO;
      tick_nxt_s = 1'b0;
    end else if (entry_s) begin
      mode_nxt_s = mode_in_s;
      cnt_nxt_s  = {CNT_W{1'b0}};
      leds_nxt_s = entry_pattern(mode_in_s, led_sel);
      tick_nxt_s = 1'b0;
    end else begin
      case (mode_r)
        MODE_OFF: begin
          leds_nxt_s = LEDS_ZERO;
        end
        MODE_BLINK: begin
          if (term_s) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            leds_nxt_s = ~leds_r;
            tick_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s  = cnt_r + CNT_W'(1'b1);
            leds_nxt_s = leds_r;
            tick_nxt_s = 1'b0;
          end
        end
        MODE_CHASE: begin
          if (term_s) begin
            cnt_nxt_s  = {CNT_W{1'b0}};
            leds_nxt_s = rotate_left(leds_r);
            tick_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s  = cnt_r + CNT_W'(1'b1);
            leds_nxt_s = leds_r;
            tick_nxt_s = 1'b0;
          end
        end
        MODE_SINGLE: begin
          // Track led_sel every cycle so the selection lags by one edge.
          leds_nxt_s = decode_sel(led_sel);
        end
        default: begin
          mode_nxt_s = MODE_OFF;
          leds_nxt_s = LEDS_ZERO;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    mode_r <= mode_nxt_s;
    cnt_r  <= cnt_nxt_s;
    leds_r <= leds_nxt_s;
    tick_r <= tick_nxt_s;
  end

  assign leds       = leds_r;
  assign phase_tick = tick_r;

endmodule

// File: tb/tb_led_pattern_engine.sv
// Scoreboard bench for led_pattern_engine. Two instances: 4 LEDs with a
// 4-cycle phase, and 3 LEDs with a 1-cycle phase. The driver pushes the
// hand-computed post-edge expectation for every cycle it drives; a monitor
// per instance pops and compares just after each rising edge.

module tb_led_pattern_engine;

  localparam logic [1:0] M_OFF = 2'b00;
  localparam logic [1:0] M_BLK = 2'b01;
  localparam logic [1:0] M_CHS = 2'b10;
  localparam logic [1:0] M_SGL = 2'b11;

  typedef struct {
    string      tag;
    logic [3:0] leds;
    logic       tick;
  } exp_t;

  logic       clk;
  logic       reset_a, reset_b;
  logic [1:0] mode_a, mode_b;
  logic [1:0] sel_a, sel_b;
  logic [3:0] leds_a;
  logic [2:0] leds_b;
  logic       tick_a, tick_b;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec;
  int   n_err;
  string cur_tag;

  led_pattern_engine #(.NUM_LEDS(4), .HALF_PERIOD(4)) u_dut_a (
    .clk(clk), .reset(reset_a), .mode(mode_a), .led_sel(sel_a),
    .leds(leds_a), .phase_tick(tick_a)
  );

  led_pattern_engine #(.NUM_LEDS(3), .HALF_PERIOD(1)) u_dut_b (
    .clk(clk), .reset(reset_b), .mode(mode_b), .led_sel(sel_b),
    .leds(leds_b), .phase_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor for the 4-LED instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        n_vec++;
        if (leds_a !== e.leds || tick_a !== e.tick) begin
          n_err++;
          $display("FAIL %s: got leds=%b tick=%b, want leds=%b tick=%b",
                   e.tag, leds_a, tick_a, e.leds, e.tick);
        end
      end
    end
  end

  // Monitor for the 3-LED instance.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        n_vec++;
        if ({1'b0, leds_b} !== e.leds || tick_b !== e.tick) begin
          n_err++;
          $display("FAIL %s: got leds=%b tick=%b, want leds=%b tick=%b",
                   e.tag, leds_b, tick_b, e.leds[2:0], e.tick);
        end
      end
    end
  end

  task automatic step_a(input logic [1:0] m, input logic [1:0] s, input logic r,
                        input logic [3:0] el, input logic et);
    exp_t e;
    mode_a = m; sel_a = s; reset_a = r;
    e.tag = cur_tag; e.leds = el; e.tick = et;
    q_a.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic step_b(input logic [1:0] m, input logic [1:0] s, input logic r,
                        input logic [2:0] el, input logic et);
    exp_t e;
    mode_b = m; sel_b = s; reset_b = r;
    e.tag = cur_tag; e.leds = {1'b0, el}; e.tick = et;
    q_b.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Hold for three steady cycles, then expect an advance to nxt with a tick.
  task automatic phase_a(input logic [1:0] m, input logic [3:0] cur, input logic [3:0] nxt);
    for (int i = 0; i < 3; i++) step_a(m, 2'd0, 1'b0, cur, 1'b0);
    step_a(m, 2'd0, 1'b0, nxt, 1'b1);
  endtask

  initial begin
    int wait_cycles;
    n_vec = 0; n_err = 0;
    mode_a = M_OFF; sel_a = 2'd0; reset_a = 1'b1;
    mode_b = M_OFF; sel_b = 2'd0; reset_b = 1'b1;

    // Reset held with BLINK requested, then released.
    cur_tag = "reset_blink";
    for (int i = 0; i < 3; i++) step_a(M_BLK, 2'd0, 1'b1, 4'b0000, 1'b0);
    step_a(M_BLK, 2'd0, 1'b0, 4'b1111, 1'b0);
    phase_a(M_BLK, 4'b1111, 4'b0000);
    phase_a(M_BLK, 4'b0000, 4'b1111);

    // CHASE full cycle including the wrap.
    cur_tag = "chase";
    step_a(M_CHS, 2'd0, 1'b0, 4'b0001, 1'b0);
    phase_a(M_CHS, 4'b0001, 4'b0010);
    phase_a(M_CHS, 4'b0010, 4'b0100);
    phase_a(M_CHS, 4'b0100, 4'b1000);
    cur_tag = "chase_wrap";
    phase_a(M_CHS, 4'b1000, 4'b0001);

    // SINGLE stepping led_sel, one-cycle lag.
    cur_tag = "single";
    step_a(M_SGL, 2'd0, 1'b0, 4'b0001, 1'b0);
    step_a(M_SGL, 2'd1, 1'b0, 4'b0010, 1'b0);
    step_a(M_SGL, 2'd2, 1'b0, 4'b0100, 1'b0);
    step_a(M_SGL, 2'd3, 1'b0, 4'b1000, 1'b0);

    // BLINK -> CHASE on the terminal-count edge: entry wins, no tick.
    cur_tag = "switch_at_term";
    step_a(M_BLK, 2'd0, 1'b0, 4'b1111, 1'b0);
    for (int i = 0; i < 3; i++) step_a(M_BLK, 2'd0, 1'b0, 4'b1111, 1'b0);
    step_a(M_CHS, 2'd0, 1'b0, 4'b0001, 1'b0);

    // BLINK -> OFF -> BLINK restarts with a full phase.
    cur_tag = "blink_restart";
    step_a(M_BLK, 2'd0, 1'b0, 4'b1111, 1'b0);
    step_a(M_OFF, 2'd0, 1'b0, 4'b0000, 1'b0);
    step_a(M_BLK, 2'd0, 1'b0, 4'b1111, 1'b0);
    phase_a(M_BLK, 4'b1111, 4'b0000);

    // One-cycle reset pulse mid-CHASE at 0100.
    cur_tag = "reset_mid_chase";
    step_a(M_CHS, 2'd0, 1'b0, 4'b0001, 1'b0);
    phase_a(M_CHS, 4'b0001, 4'b0010);
    phase_a(M_CHS, 4'b0010, 4'b0100);
    step_a(M_CHS, 2'd0, 1'b1, 4'b0000, 1'b0);
    step_a(M_CHS, 2'd0, 1'b0, 4'b0001, 1'b0);
    phase_a(M_CHS, 4'b0001, 4'b0010);
    step_a(M_OFF, 2'd0, 1'b0, 4'b0000, 1'b0);

    // 3 LEDs, HALF_PERIOD=1.
    cur_tag = "n3_reset";
    step_b(M_OFF, 2'd0, 1'b1, 3'b000, 1'b0);
    cur_tag = "n3_chase";
    step_b(M_CHS, 2'd0, 1'b0, 3'b001, 1'b0);
    step_b(M_CHS, 2'd0, 1'b0, 3'b010, 1'b1);
    step_b(M_CHS, 2'd0, 1'b0, 3'b100, 1'b1);
    step_b(M_CHS, 2'd0, 1'b0, 3'b001, 1'b1);
    step_b(M_CHS, 2'd0, 1'b0, 3'b010, 1'b1);
    cur_tag = "n3_single";
    step_b(M_SGL, 2'd3, 1'b0, 3'b000, 1'b0);
    step_b(M_SGL, 2'd1, 1'b0, 3'b010, 1'b0);
    step_b(M_SGL, 2'd3, 1'b0, 3'b000, 1'b0);
    step_b(M_SGL, 2'd2, 1'b0, 3'b100, 1'b0);
    cur_tag = "n3_off";
    step_b(M_OFF, 2'd2, 1'b0, 3'b000, 1'b0);

    // Drain both scoreboards with a bounded wait.
    wait_cycles = 0;
    while ((q_a.size() > 0 || q_b.size() > 0) && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #3;
    if (q_a.size() > 0 || q_b.size() > 0) begin
      n_err++;
      $display("FAIL drain: got %0d expectations left, want 0", q_a.size() + q_b.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/led_pattern_engine.md
# led_pattern_engine

Parametrised LED driver for the reaction-timer board. It replaces the fixed 4-LED blinker with a mode-selectable engine: off, all-LED blink, chase and single-LED test. The engine owns one phase counter and drives the board LED bank directly. Its modes are selected by the game controller FSM (idle/attract → blink or chase; stimulus → single).

## Interface
Parameters:
- NUM_LEDS, 4: number of LED outputs; must be ≥ 2.
- HALF_PERIOD, 50000000: clk cycles per pattern phase; must be ≥ 1 (50 MHz → 1 s).
- Derived (localparam): CNT_W = max(1, clog2(HALF_PERIOD)); SEL_W = max(1, clog2(NUM_LEDS)).

Ports:
- clk, in, 1: system clock. One clock domain only.
- reset, in, 1: synchronous, active-high reset.
- mode, in, 2: 00 OFF, 01 BLINK, 10 CHASE, 11 SINGLE. Sampled every clk edge.
- led_sel, in, SEL_W: LED index used in SINGLE mode.
- leds, out, NUM_LEDS: registered LED drive, 1 = on.
- phase_tick, out, 1: one-cycle pulse on each pattern advance in BLINK/CHASE.

## Operation
- Registers: mode_q (last sampled mode), cnt (CNT_W), leds, phase_tick.
- Reset (reset=1 at an edge): leds=0, cnt=0, mode_q=OFF, phase_tick=0. Reset overrides all other inputs. Asserting reset mid-pattern aborts the pattern immediately.
- Mode entry: the edge where mode ≠ mode_q is an entry edge. At that edge mode_q←mode, cnt←0, phase_tick←0, and leds←entry value:
  - OFF: all 0.
  - BLINK: all 1.
  - CHASE: one-hot bit 0.
  - SINGLE: the decoded led_sel.
- Steady BLINK/CHASE (mode = mode_q):
  - If cnt == HALF_PERIOD-1: cnt←0, phase_tick←1, pattern advances.
    - BLINK advance: leds←~leds.
    - CHASE advance: rotate left by one. Bit NUM_LEDS-1 wraps to bit 0.
  - Otherwise: cnt←cnt+1, phase_tick←0, leds hold.
- Steady OFF: leds=0, cnt=0, phase_tick=0.
- Steady SINGLE: leds←one-hot(led_sel) every edge. cnt=0, phase_tick=0.
  - If led_sel ≥ NUM_LEDS, leds←0. This is the out-of-range case, possible when NUM_LEDS is not a power of 2.
- Simultaneous entry and terminal count: the entry wins. There is no tick, and the pattern loads the entry value.
- Return to the same mode after leaving it always restarts from the entry value. No pattern state is retained.
- HALF_PERIOD=1: the pattern advances on every steady edge and phase_tick stays high continuously.

## Timing
- All outputs are registered and glitch-free. There is no combinational path from inputs to outputs.
- Mode change latency: 1 cycle. A mode applied before edge T is reflected on leds after edge T.
- SINGLE led_sel latency: 1 cycle.
- BLINK/CHASE cadence, for an entry at edge T:
  - Advances occur at edges T+k·HALF_PERIOD, k ≥ 1.
  - phase_tick is high for exactly the cycle following each advance edge.
  - The new pattern and the tick become visible together.
- Full period: BLINK is 2·HALF_PERIOD cycles. CHASE is NUM_LEDS·HALF_PERIOD cycles.
- Release of reset: the first non-reset edge is an entry edge if mode ≠ OFF.

## Test plan
Benches use NUM_LEDS=4 and HALF_PERIOD=4 unless stated.
- Reset with mode=BLINK for 3 cycles, then release → leds=0000 and phase_tick=0 during reset. leds=1111 after the first free edge; 0000 after 4 more edges, with phase_tick high for that one cycle; 1111 after 4 more edges.
- CHASE entry → leds 0001, 0010, 0100, 1000, 0001, each held 4 cycles. Exactly one phase_tick per transition, and the 1000→0001 wrap is verified.
- SINGLE with led_sel stepping 0,1,2,3 each cycle → leds 0001, 0010, 0100, 1000, each lagging led_sel by 1 cycle. phase_tick stays 0.
- Mode switch BLINK→CHASE on the same edge that cnt=3 → no tick, leds=0001 at that edge. Then BLINK→OFF→BLINK restarts at 1111 with a full 4-cycle phase.
- Reset pulsed for one cycle mid-CHASE (leds=0100) → leds=0000 and cnt=0 the next cycle. CHASE then restarts at 0001.
- NUM_LEDS=3, HALF_PERIOD=1: CHASE rotates 001→010→100→001 every cycle with phase_tick held high. SINGLE with led_sel=3 → leds=000.
